ysyx_22050854_wb_arbiter: RTL and testbench
===========================================

# ysyx_22050854_wb_arbiter

Writeback arbiter and scoreboard sitting directly upstream of the 64-bit general-purpose register file write port. It merges results from the single-cycle path (ALU/load) and the multi-cycle path (mul/div) into the register file's single write port (`wen`/`waddr`/`wdata`). It buffers multi-cycle results in a small FIFO and tracks pending destination registers so the issue stage can stall on RAW/WAW hazards.

## Interface
Parameters:
- `XLEN`, 64, data width.
- `DEPTH`, 2, slow-result FIFO entries (power of two, ≥2).

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `fast_valid`  in  1  single-cycle result present this cycle; no backpressure, must be consumed.
- `fast_rd`  in  5  destination of fast result.
- `fast_data`  in  XLEN  fast result.
- `slow_valid`  in  1  multi-cycle result offered.
- `slow_ready`  out  1  FIFO can accept; transfer when `slow_valid && slow_ready`.
- `slow_rd`  in  5  destination of slow result.
- `slow_data`  in  XLEN  slow result.
- `iss_valid`  in  1  a multi-cycle op issues this cycle.
- `iss_rd`  in  5  its destination.
- `chk_rs1`, `chk_rs2`, `chk_rd`  in  5 each  operands/destination of the instruction in issue.
- `hazard`  out  1  any checked register is pending.
- `busy`  out  32  pending-write vector, bit i = x_i.
- `wen`  out  1  register-file write enable.
- `waddr`  out  5  register-file write address.
- `wdata`  out  XLEN  register-file write data.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- Reset (`reset_n`=0 at edge): `busy`=0, FIFO empty, `wen`=0, `waddr`=0, `wdata`=0, `err`=0. `slow_ready` is 0 while `reset_n`=0 and 1 from the first cycle after release.
- Per-cycle select, registered to the write outputs at the edge:
  1. `fast_valid` && `fast_rd`≠0 → write fast.
  2. Otherwise, FIFO non-empty → pop head and write it.
  3. Otherwise, `wen`=0, `waddr`=0, `wdata`=0.
- The fast path always wins; the FIFO head waits and may starve indefinitely under back-to-back fast traffic.
- `fast_valid` with `fast_rd`=0 is dropped, and the FIFO may pop in that cycle.
- Slow accept: on handshake, an entry {rd, data} is enqueued. `slow_rd`=0 is accepted and discarded (not enqueued).
- `slow_ready` = (count < DEPTH), computed from registered count only; a same-cycle pop does not raise it.
- FIFO order is strictly in-order; count range is 0..DEPTH.
- Enqueue and pop in the same cycle leave count unchanged.
- Scoreboard:
  - `iss_valid` && `iss_rd`≠0 sets `busy[iss_rd]`.
  - A popped FIFO entry clears `busy[rd]` at the same edge that registers its write.
  - Simultaneous set and clear of the same bit: set wins.
  - `busy[0]` is always 0.
- `hazard` = `busy[chk_rs1]` | `busy[chk_rs2]` | `busy[chk_rd]`, with index 0 ignored. It is combinational from registered `busy`; the scoreboard provides no forwarding.
- `err` is set (sticky until reset) on any of:
  - `fast_valid` with `busy[fast_rd]`=1 (WAW violation);
  - slow handshake whose rd≠0 has `busy[rd]`=0;
  - `iss_valid` to an already-busy rd.

## Timing
- Fast: `fast_valid` at cycle N → `wen`=1 with `waddr`/`wdata` at cycle N+1, held one cycle.
- Slow, uncontended: handshake at N → entry in FIFO at N+1 → `wen` at N+2 → `busy` bit clear at N+2 → `hazard` falls at N+2.
- Each contending fast cycle adds one cycle of slow latency.
- `busy` bit visible the cycle after `iss_valid`.
- Throughput: one register-file write per cycle; sustained slow acceptance is 1/cycle only when no fast traffic is present.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with all inputs toggling → `wen`=0, `busy`=0, `err`=0, `slow_ready`=0; after release, `slow_ready`=1.
- Fast write: `fast_valid`=1, rd=5, data=0x1234 at N → N+1 has `wen`=1, `waddr`=5, `wdata`=0x1234. A second fast write with rd=0 gives `wen`=0.
- Slow path and scoreboard:
  - `iss_valid`, rd=7 → `busy[7]`=1; `chk_rs1`=7 gives `hazard`=1.
  - Slow result rd=7, data=0xDEAD, handshake at N → `wen` at N+2 with `waddr`=7, `wdata`=0xDEAD.
  - `busy[7]`=0 and `hazard`=0 at N+2.
- Contention: slow results rd=3 then rd=4 enqueued while fast writes rd=1,2,8 stream on 3 consecutive cycles:
  - 3rd slow offer sees `slow_ready`=0.
  - Write order is 1,2,8,3,4.
  - `busy[3]` clears before `busy[4]`.
- Simultaneous set/clear: slow rd=9 pops the same cycle `iss_valid` rd=9 → `busy[9]` remains 1.
- Violation: `busy[6]`=1, then `fast_valid` rd=6 → `err`=1 next cycle and stays 1 until reset.

Source files
------------

// File: rtl/ysyx_22050854_wb_arbiter.sv
// Writeback arbiter: merges single-cycle and multi-cycle results onto one
// register-file write port and tracks pending destinations for hazard checks.
module ysyx_22050854_wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            fast_valid,
    input  logic [4:0]      fast_rd,
    input  logic [XLEN-1:0] fast_data,
    input  logic            slow_valid,
    output logic            slow_ready,
    input  logic [4:0]      slow_rd,
    input  logic [XLEN-1:0] slow_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic [31:0]     busy,
    output logic            wen,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic            err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]      r_fifo_rd   [DEPTH];
    logic [XLEN-1:0] r_fifo_data [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_busy;
    logic            r_wen;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            r_err;

    logic            w_fast_wr;
    logic            w_pop;
    logic            w_hs;
    logic            w_push;
    logic            w_err_hit;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic [31:0]     w_busy_next;

    // Ready depends only on the registered count so a same-cycle pop never
    // creates a combinational path from the fast port to slow_ready.
    assign slow_ready  = reset_n && (r_count < FULL);
    assign w_fast_wr   = fast_valid && (fast_rd != 5'd0);
    assign w_pop       = !w_fast_wr && (r_count != '0);
    assign w_hs        = slow_valid && slow_ready;
    assign w_push      = w_hs && (slow_rd != 5'd0);
    assign w_head_rd   = r_fifo_rd[r_head];
    assign w_head_data = r_fifo_data[r_head];

    assign w_err_hit = (fast_valid && r_busy[fast_rd])
                     || (w_hs && (slow_rd != 5'd0) && !r_busy[slow_rd])
                     || (iss_valid && r_busy[iss_rd]);

    // Issue sets after the pop clears, so a same-cycle set on a bit wins.
    assign w_busy_next[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            assign w_busy_next[gi] = (iss_valid && (iss_rd == 5'(gi)))
                                   || (r_busy[gi] && !(w_pop && (w_head_rd == 5'(gi))));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_rd[r_tail]   <= slow_rd;
            r_fifo_data[r_tail] <= slow_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_fast_wr) begin
                r_wen   <= 1'b1;
                r_waddr <= fast_rd;
                r_wdata <= fast_data;
            end else if (w_pop) begin
                r_wen   <= 1'b1;
                r_waddr <= w_head_rd;
                r_wdata <= w_head_data;
            end else begin
                r_wen   <= 1'b0;
                r_waddr <= '0;
                r_wdata <= '0;
            end
            r_busy <= w_busy_next;
            if (w_err_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign hazard = ((chk_rs1 != 5'd0) && r_busy[chk_rs1])
                 || ((chk_rs2 != 5'd0) && r_busy[chk_rs2])
                 || ((chk_rd  != 5'd0) && r_busy[chk_rd]);
    assign busy  = r_busy;
    assign wen   = r_wen;
    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign err   = r_err;

endmodule

// File: tb/tb_ysyx_22050854_wb_arbiter.sv
// Bench for the writeback arbiter: directed scenarios plus random legal
// traffic, all checked against a queue-based reference model.
module tb_ysyx_22050854_wb_arbiter;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            fast_valid;
    logic [4:0]      fast_rd;
    logic [XLEN-1:0] fast_data;
    logic            slow_valid;
    logic            slow_ready;
    logic [4:0]      slow_rd;
    logic [XLEN-1:0] slow_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            hazard;
    logic [31:0]     busy;
    logic            wen;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            err;

    always #5 clock = ~clock;

    ysyx_22050854_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .fast_valid (fast_valid),
        .fast_rd    (fast_rd),
        .fast_data  (fast_data),
        .slow_valid (slow_valid),
        .slow_ready (slow_ready),
        .slow_rd    (slow_rd),
        .slow_data  (slow_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .hazard     (hazard),
        .busy       (busy),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .err        (err)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    int              n_tests = 0;
    int              n_fail  = 0;
    ent_t            m_q[$];
    logic [31:0]     m_busy;
    logic            m_wen;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;
    logic            m_err;
    logic [4:0]      outstanding[$];
    logic [4:0]      wr_log[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_haz();
        return ((chk_rs1 != 5'd0) && m_busy[chk_rs1])
            || ((chk_rs2 != 5'd0) && m_busy[chk_rs2])
            || ((chk_rd  != 5'd0) && m_busy[chk_rd]);
    endfunction

    // Reference model: one clock edge worth of behaviour from current inputs.
    task automatic model_step();
        ent_t e;
        logic fw;
        logic hs;
        if (!reset_n) begin
            m_q.delete();
            m_busy  = '0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_err   = 1'b0;
            return;
        end
        fw = fast_valid && (fast_rd != 5'd0);
        hs = slow_valid && (m_q.size() < DEPTH);
        if ((fast_valid && m_busy[fast_rd]) || (hs && slow_rd != 5'd0 && !m_busy[slow_rd])
            || (iss_valid && m_busy[iss_rd]))
            m_err = 1'b1;
        if (fw) begin
            m_wen = 1'b1; m_waddr = fast_rd; m_wdata = fast_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_wen = 1'b1; m_waddr = e.rd; m_wdata = e.data;
            m_busy[e.rd] = 1'b0;
        end else begin
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        end
        if (hs && slow_rd != 5'd0) m_q.push_back('{slow_rd, slow_data});
        if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        m_busy[0] = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_val("wen",        64'(wen),        64'(m_wen));
        check_val("waddr",      64'(waddr),      64'(m_waddr));
        check_val("wdata",      wdata,           m_wdata);
        check_val("busy",       64'(busy),       64'(m_busy));
        check_val("err",        64'(err),        64'(m_err));
        check_val("slow_ready", 64'(slow_ready), 64'(reset_n && (m_q.size() < DEPTH)));
        check_val("hazard",     64'(hazard),     64'(exp_haz()));
        if (wen) begin
            wr_log.push_back(waddr);
            $display("[TB] write x%0d <= 0x%016h", waddr, wdata);
        end
    endtask

    task automatic set_idle();
        fast_valid = 1'b0; fast_rd = '0; fast_data = '0;
        slow_valid = 1'b0; slow_rd = '0; slow_data = '0;
        iss_valid  = 1'b0; iss_rd  = '0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) begin
            fast_valid = 1'($urandom); fast_rd = 5'($urandom); fast_data = {$urandom, $urandom};
            slow_valid = 1'($urandom); slow_rd = 5'($urandom); slow_data = {$urandom, $urandom};
            iss_valid  = 1'($urandom); iss_rd  = 5'($urandom);
            tick();
        end
        set_idle();
        reset_n = 1'b1;
        outstanding.delete();
    endtask

    initial begin
        int idx;
        logic [4:0] r;
        reset_n = 1'b0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        set_idle();

        // Reset with toggling inputs, then ready rises on release.
        do_reset(3);
        #1;
        check_val("ready_after_rst", 64'(slow_ready), 64'd1);
        tick();

        // Fast write, then a dropped write to x0.
        fast_valid = 1'b1; fast_rd = 5'd5; fast_data = 64'h1234;
        tick();
        check_val("fast_wen", 64'(wen), 64'd1);
        check_val("fast_waddr", 64'(waddr), 64'd5);
        check_val("fast_wdata", wdata, 64'h1234);
        fast_rd = 5'd0; fast_data = 64'h5555;
        tick();
        check_val("fast_x0_wen", 64'(wen), 64'd0);
        set_idle();

        // Issue x7, observe hazard, then slow result two cycles after handshake.
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        set_idle();
        chk_rs1 = 5'd7;
        #1;
        check_val("busy7_set", 64'(busy[7]), 64'd1);
        check_val("hazard7", 64'(hazard), 64'd1);
        slow_valid = 1'b1; slow_rd = 5'd7; slow_data = 64'hDEAD;
        tick();
        set_idle();
        check_val("slow_n1_wen", 64'(wen), 64'd0);
        tick();
        check_val("slow_wen", 64'(wen), 64'd1);
        check_val("slow_waddr", 64'(waddr), 64'd7);
        check_val("slow_wdata", wdata, 64'hDEAD);
        check_val("busy7_clr", 64'(busy[7]), 64'd0);
        check_val("hazard7_clr", 64'(hazard), 64'd0);
        chk_rs1 = '0;

        // Contention: slow x3, x4 queued behind fast x1, x2, x8.
        iss_valid = 1'b1; iss_rd = 5'd3; tick();
        iss_rd = 5'd4; tick();
        set_idle();
        wr_log.delete();
        fast_valid = 1'b1; fast_rd = 5'd1; fast_data = 64'h11;
        slow_valid = 1'b1; slow_rd = 5'd3; slow_data = 64'h33;
        tick();
        fast_rd = 5'd2; fast_data = 64'h22;
        slow_rd = 5'd4; slow_data = 64'h44;
        tick();
        fast_rd = 5'd8; fast_data = 64'h88;
        slow_rd = 5'd4; slow_data = 64'h99;
        #1;
        check_val("third_offer_ready", 64'(slow_ready), 64'd0);
        tick();
        set_idle();
        tick();
        check_val("busy3_first", 64'(busy[3]), 64'd0);
        check_val("busy4_still", 64'(busy[4]), 64'd1);
        tick();
        check_val("busy4_clr", 64'(busy[4]), 64'd0);
        check_val("order_len", 64'(wr_log.size()), 64'd5);
        if (wr_log.size() == 5) begin
            check_val("order0", 64'(wr_log[0]), 64'd1);
            check_val("order1", 64'(wr_log[1]), 64'd2);
            check_val("order2", 64'(wr_log[2]), 64'd8);
            check_val("order3", 64'(wr_log[3]), 64'd3);
            check_val("order4", 64'(wr_log[4]), 64'd4);
        end

        // Same-cycle pop of x9 and re-issue of x9: set wins.
        iss_valid = 1'b1; iss_rd = 5'd9; tick();
        set_idle();
        slow_valid = 1'b1; slow_rd = 5'd9; slow_data = 64'h9999; tick();
        set_idle();
        iss_valid = 1'b1; iss_rd = 5'd9; tick();
        set_idle();
        check_val("setclr_waddr", 64'(waddr), 64'd9);
        check_val("setclr_busy9", 64'(busy[9]), 64'd1);

        // WAW violation on x6 is sticky until reset.
        do_reset(2);
        tick();
        check_val("err_after_rst", 64'(err), 64'd0);
        iss_valid = 1'b1; iss_rd = 5'd6; tick();
        set_idle();
        check_val("err_pre_waw", 64'(err), 64'd0);
        fast_valid = 1'b1; fast_rd = 5'd6; fast_data = 64'h66; tick();
        set_idle();
        check_val("err_waw", 64'(err), 64'd1);
        repeat (3) tick();
        check_val("err_sticky", 64'(err), 64'd1);

        // Random legal traffic.
        do_reset(2);
        repeat (400) begin
            set_idle();
            chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom); chk_rd = 5'($urandom);
            if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, outstanding.size() - 1);
                slow_valid = 1'b1; slow_rd = outstanding[idx]; slow_data = {$urandom, $urandom};
                if (m_q.size() < DEPTH) outstanding.delete(idx);
            end else if ($urandom_range(0, 7) == 0) begin
                slow_valid = 1'b1; slow_rd = 5'd0; slow_data = {$urandom, $urandom};
            end
            if ($urandom_range(0, 2) == 0) begin
                r = 5'($urandom);
                if (!m_busy[r]) begin
                    iss_valid = 1'b1; iss_rd = r;
                    if (r != 5'd0) outstanding.push_back(r);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                r = 5'($urandom);
                fast_valid = 1'b1; fast_rd = m_busy[r] ? 5'd0 : r; fast_data = {$urandom, $urandom};
            end
            tick();
        end
        set_idle();
        repeat (4) tick();
        check_val("err_random", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
